// File: rtl/proc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle processor control unit:
// opcodes, time-step encoding and instruction field positions.
package proc_pkg;

  localparam int DIN_W = 16;
  localparam int IR_W  = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  localparam int III_HI = 8;
  localparam int III_LO = 6;
  localparam int X_HI   = 5;
  localparam int X_LO   = 3;
  localparam int Y_HI   = 2;
  localparam int Y_LO   = 0;

  function automatic logic is_addsub(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Run/DIN request side plus all control strobes of the processor control unit.
// Handshake: Run is a level request, sampled only when Tstep==T0; DIN must hold
// the instruction in that cycle and the mvi immediate in the following T1.
interface proc_ctrl_fsm_if;
  import proc_pkg::*;

  logic              Run;
  logic [DIN_W-1:0]  DIN;
  logic [2:0]        Rin_sel;
  logic              Rin_en;
  logic [2:0]        Rout_sel;
  logic              Rout_en;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              AddSub;
  logic              DINout;
  logic              Done;
  logic [1:0]        Tstep;
  logic [IR_W-1:0]   IR;

  modport master (
    output Run, DIN,
    input  Rin_sel, Rin_en, Rout_sel, Rout_en, Ain, Gin, Gout, AddSub,
           DINout, Done, Tstep, IR
  );

  modport slave (
    input  Run, DIN,
    output Rin_sel, Rin_en, Rout_sel, Rout_en, Ain, Gin, Gout, AddSub,
           DINout, Done, Tstep, IR
  );

endinterface

// File: rtl/proc_ctrl_fsm_step_counter.sv
// Time-step register: leaves T0 only on a start request, walks forward
// otherwise, and snaps back to T0 whenever the instruction retires or aborts.
module proc_step_counter
  import proc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   clr,
  output tstep_t tstep
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstep <= T0;
    end else if (clr) begin
      tstep <= T0;
    end else if (tstep == T0) begin
      if (start) tstep <= T1;
    end else begin
      tstep <= tstep_t'(tstep + 2'd1);
    end
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multicycle control unit: latches the instruction in T0 and decodes
// register/ALU/bus strobes from the current time step and opcode.
module proc_ctrl_fsm
  import proc_pkg::*;
(
  input  logic            Clock,
  input  logic            Resetn,
  proc_ctrl_fsm_if.slave  bus
);

  tstep_t          tstep;
  logic [IR_W-1:0] ir;
  logic [2:0]      op, x, y;
  logic [2:0]      rin_sel, rout_sel;
  logic            rin_en, rout_en, ain, gin, gout, addsub, dinout, done;
  logic            clr;
  logic            unused_din;

  assign op = ir[III_HI:III_LO];
  assign x  = ir[X_HI:X_LO];
  assign y  = ir[Y_HI:Y_LO];

  // Only the low IR_W bits of DIN carry the instruction.
  assign unused_din = ^bus.DIN[DIN_W-1:IR_W];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir <= '0;
    end else if (tstep == T0 && bus.Run) begin
      ir <= bus.DIN[IR_W-1:0];
    end
  end

  always_comb begin
    rin_sel  = 3'd0;
    rin_en   = 1'b0;
    rout_sel = 3'd0;
    rout_en  = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    addsub   = 1'b0;
    dinout   = 1'b0;
    done     = 1'b0;
    case (tstep)
      T1: begin
        case (op)
          OP_MV: begin
            rout_sel = y;
            rout_en  = 1'b1;
            rin_sel  = x;
            rin_en   = 1'b1;
            done     = 1'b1;
          end
          OP_MVI: begin
            dinout  = 1'b1;
            rin_sel = x;
            rin_en  = 1'b1;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_sel = x;
            rout_en  = 1'b1;
            ain      = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        if (is_addsub(op)) begin
          rout_sel = y;
          rout_en  = 1'b1;
          gin      = 1'b1;
          addsub   = op[0];
        end
      end
      T3: begin
        if (is_addsub(op)) begin
          gout    = 1'b1;
          rin_sel = x;
          rin_en  = 1'b1;
          done    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A T2/T3 with a non-ALU opcode can only come from corruption; recover to T0.
  assign clr = done || ((tstep == T2 || tstep == T3) && !is_addsub(op));

  proc_step_counter u_step (
    .clk   (Clock),
    .rst_n (Resetn),
    .start (bus.Run),
    .clr   (clr),
    .tstep (tstep)
  );

  assign bus.Rin_sel  = rin_sel;
  assign bus.Rin_en   = rin_en;
  assign bus.Rout_sel = rout_sel;
  assign bus.Rout_en  = rout_en;
  assign bus.Ain      = ain;
  assign bus.Gin      = gin;
  assign bus.Gout     = gout;
  assign bus.AddSub   = addsub;
  assign bus.DINout   = dinout;
  assign bus.Done     = done;
  assign bus.Tstep    = tstep;
  assign bus.IR       = ir;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: vector table plus hand-written reset
// sequences, with expected outputs queued at drive time and compared on sample.
module tb_proc_ctrl_fsm;
  import proc_pkg::*;

  localparam int OW = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  proc_ctrl_fsm_if bus ();

  proc_ctrl_fsm dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          run;
    logic [15:0]   din;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t          tbl[17];
  logic [OW-1:0] exp_q[$];
  int            n_tests   = 0;
  int            n_fail    = 0;
  logic          prev_done = 1'b0;
  logic [OW-1:0] zr;

  // Field order: rin_sel rin_en rout_sel rout_en ain gin gout addsub dinout done tstep ir
  function automatic logic [OW-1:0] mk(
    input logic [2:0] rin_sel, input logic rin_en,
    input logic [2:0] rout_sel, input logic rout_en,
    input logic ain, input logic gin, input logic gout, input logic addsub,
    input logic dinout, input logic done, input logic [1:0] ts, input logic [8:0] ir
  );
    return {rin_sel, rin_en, rout_sel, rout_en, ain, gin, gout, addsub,
            dinout, done, ts, ir};
  endfunction

  function automatic logic [OW-1:0] pack_out();
    return {bus.Rin_sel, bus.Rin_en, bus.Rout_sel, bus.Rout_en, bus.Ain, bus.Gin,
            bus.Gout, bus.AddSub, bus.DINout, bus.Done, bus.Tstep, bus.IR};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input string name);
    logic [OW-1:0] e;
    e = exp_q.pop_front();
    check(name, pack_out(), e);
    check_bit({name, "_bus_excl"},
              ({1'b0, bus.Rout_en} + {1'b0, bus.Gout} + {1'b0, bus.DINout}) <= 2'd1, 1'b1);
    check_bit({name, "_done_width"}, prev_done && bus.Done, 1'b0);
    check_bit({name, "_addsub_gin"}, bus.AddSub && !bus.Gin, 1'b0);
    check_bit({name, "_sel_zero"},
              (!bus.Rin_en && bus.Rin_sel != 3'd0) || (!bus.Rout_en && bus.Rout_sel != 3'd0),
              1'b0);
    prev_done = bus.Done;
  endtask

  task automatic step(input string name, input logic run, input logic [15:0] din,
                      input logic [OW-1:0] e);
    @(negedge clk);
    bus.Run = run;
    bus.DIN = din;
    exp_q.push_back(e);
    #1;
    sample(name);
  endtask

  initial begin
    bus.Run = 1'b1;
    bus.DIN = 16'h0081;
    zr = mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h000);

    tbl[0]  = '{1'b1, 16'h0050, zr};
    tbl[1]  = '{1'b0, 16'h1234, mk(2,1,0,0,0,0,0,0,1,1,2'd1,9'h050)};
    tbl[2]  = '{1'b1, 16'h000B, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h050)};
    tbl[3]  = '{1'b0, 16'h0000, mk(1,1,3,1,0,0,0,0,0,1,2'd1,9'h00B)};
    tbl[4]  = '{1'b1, 16'h00FE, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h00B)};
    tbl[5]  = '{1'b0, 16'h0000, mk(0,0,7,1,1,0,0,0,0,0,2'd1,9'h0FE)};
    tbl[6]  = '{1'b1, 16'h0081, mk(0,0,6,1,0,1,0,1,0,0,2'd2,9'h0FE)};
    tbl[7]  = '{1'b0, 16'h0000, mk(7,1,0,0,0,0,1,0,0,1,2'd3,9'h0FE)};
    tbl[8]  = '{1'b1, 16'h0081, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h0FE)};
    tbl[9]  = '{1'b0, 16'h0000, mk(0,0,0,1,1,0,0,0,0,0,2'd1,9'h081)};
    tbl[10] = '{1'b0, 16'h0000, mk(0,0,1,1,0,1,0,0,0,0,2'd2,9'h081)};
    tbl[11] = '{1'b0, 16'h0000, mk(0,1,0,0,0,0,1,0,0,1,2'd3,9'h081)};
    tbl[12] = '{1'b1, 16'h01C0, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h081)};
    tbl[13] = '{1'b1, 16'h0050, mk(0,0,0,0,0,0,0,0,0,1,2'd1,9'h1C0)};
    tbl[14] = '{1'b1, 16'h0050, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h1C0)};
    tbl[15] = '{1'b0, 16'h0000, mk(2,1,0,0,0,0,0,0,1,1,2'd1,9'h050)};
    tbl[16] = '{1'b0, 16'h0000, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h050)};

    // Reset held with Run asserted: nothing may move.
    step("reset_hold0", 1'b1, 16'h0081, zr);
    step("reset_hold1", 1'b1, 16'h0081, zr);
    @(negedge clk);
    bus.Run = 1'b0;
    rst_n   = 1'b1;

    for (int i = 0; i < 17; i++)
      step($sformatf("vec%0d", i), tbl[i].run, tbl[i].din, tbl[i].exp);

    // Abort an add in T2 with an asynchronous reset.
    step("midop_t0", 1'b1, 16'h0081, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h050));
    step("midop_t1", 1'b0, 16'h0000, mk(0,0,0,1,1,0,0,0,0,0,2'd1,9'h081));
    step("midop_t2", 1'b0, 16'h0000, mk(0,0,1,1,0,1,0,0,0,0,2'd2,9'h081));
    rst_n = 1'b0;
    #1;
    exp_q.push_back(zr);
    sample("midop_reset");
    step("midop_hold0", 1'b1, 16'h0081, zr);
    step("midop_hold1", 1'b1, 16'h0081, zr);
    @(negedge clk);
    bus.Run = 1'b0;
    rst_n   = 1'b1;
    step("post_reset0", 1'b0, 16'h0000, zr);
    step("post_reset1", 1'b0, 16'h0000, zr);
    step("resume_t0",   1'b1, 16'h000B, zr);
    step("resume_t1",   1'b0, 16'h0000, mk(1,1,3,1,0,0,0,0,0,1,2'd1,9'h00B));
    step("resume_idle", 1'b0, 16'h0000, mk(0,0,0,0,0,0,0,0,0,0,2'd0,9'h00B));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Multicycle control unit for the simple 16-bit processor.
- Latches the 9-bit instruction from DIN, then steps through time steps T0..T3.
- Emits register-select indices plus enables that feed the two datapath 3-to-8 register decoders: a load-enable decoder and a bus-source decoder.
- Also drives the ALU and bus control strobes, and signals Done when an instruction retires.

Parameters:
- DIN_W, 16, width of the data-in bus.
- IR_W, 9, instruction register width; instruction fields are DIN[8:6]=opcode III, DIN[5:3]=X, DIN[2:0]=Y.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request, sampled only in T0.
- DIN  in  DIN_W  instruction word in T0; immediate data for mvi in T1.
- Rin_sel  out  3  register index to load; drives load-decoder W.
- Rin_en  out  1  load-decoder En.
- Rout_sel  out  3  register index driven onto the bus; drives source-decoder W.
- Rout_en  out  1  source-decoder En.
- Ain  out  1  load A from bus.
- Gin  out  1  load G from ALU.
- Gout  out  1  G drives bus.
- AddSub  out  1  0=add, 1=sub.
- DINout  out  1  DIN drives bus.
- Done  out  1  instruction complete this cycle.
- Tstep  out  2  current time step, for debug.
- IR  out  IR_W  latched instruction.

Behaviour:
- Reset (Resetn=0, async): Tstep=T0, IR=0. While reset is asserted, every control output is forced to 0 regardless of Run. Reset mid-instruction aborts it with no Done; the instruction is lost.
- Registered state: Tstep (2 bits) and IR. All control outputs are combinational from Tstep, IR and, in T0 only, Run.
- T0:
  - Run=0: all outputs 0; stay in T0.
  - Run=1: IR <= DIN[8:0] at the clock edge; go to T1. No other strobes in T0.
- Opcode 000, mv Rx,Ry:
  - T1: Rout_sel=Y, Rout_en=1, Rin_sel=X, Rin_en=1, Done=1. Then T0.
- Opcode 001, mvi Rx,#D:
  - T1: DINout=1, Rin_sel=X, Rin_en=1, Done=1. Then T0.
- Opcode 010/011, add/sub Rx,Ry:
  - T1: Rout_sel=X, Rout_en=1, Ain=1.
  - T2: Rout_sel=Y, Rout_en=1, Gin=1, AddSub=opcode[0].
  - T3: Gout=1, Rin_sel=X, Rin_en=1, Done=1. Then T0.
- Opcodes 100..111 (undefined): T1 Done=1 only, no enables. Then T0.
- Latency from Run sampled to Done: mv/mvi/undefined 1 cycle after the T0 edge; add/sub 3 cycles.
- Run is ignored outside T0. Run held high gives back-to-back instructions: Done in cycle n, next IR latched in cycle n+1.
- AddSub is 0 whenever Gin=0.
- Rin_sel and Rout_sel are 0 whenever their enable is 0.
- Invariant, bus exclusivity: at most one of Rout_en, Gout, DINout is high in any cycle.
- Invariant: Done is high for exactly one cycle per instruction.
- Tstep never takes an unreachable value. If it is corrupted to T2/T3 with a non-add/sub IR, it returns to T0 next cycle with no strobes.

Decomposition:
- Shared package proc_pkg holds:
  - opcode localparams OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011.
  - time-step constants T0..T3 (2-bit).
  - field bit positions for III/X/Y.
- Natural sub-module: proc_step_counter, a 2-bit step register with sync clear on Done and async reset, which advances when Run is sampled in T0.
- The two dec3to8 instances live in the datapath, not in this block.

Test Plan:
- Reset: Resetn=0 with Run=1 and DIN=16'h0081 -> all outputs 0, Tstep=0, IR=0. Release reset -> T0 with IRin behaviour resumes.
- mvi R2: Run=1, DIN=16'h0050 at T0, then DIN=16'h1234 in T1 -> T1 shows DINout=1, Rin_sel=2, Rin_en=1, Done=1, Rout_en=0. Next cycle Tstep=0.
- mv R1,R3: DIN=16'h000B -> T1 shows Rout_sel=3, Rout_en=1, Rin_sel=1, Rin_en=1, Done=1.
- sub R7,R6: DIN=16'h00FE -> T1 Rout_sel=7 with Ain; T2 Rout_sel=6 with Gin and AddSub=1; T3 Gout with Rin_sel=7 and Done. Repeat with add (16'h0081): same sequence with AddSub=0.
- Reset mid-op: DIN=16'h0081, assert Resetn=0 during T2 -> outputs drop to 0 immediately, no Done, Tstep=0. Run ignored while Tstep≠0 (pulse Run in T2 of a later add -> no effect).
- Back-to-back and undefined: Run held 1 with DIN sequence 16'h01C0, 16'h0050 -> Done in T1 of each with no enables for the first. Every cycle checks bus exclusivity and Done pulse width = 1.
